// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : op encodings, FSM states and default width for the mul/div unit
// Revision   : 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_step : one iteration of shift-add multiply or restoring divide
// Revision    : 1.0
// ---------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               bit_in,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] w_shrem;
  logic [WIDTH:0] w_trial;

  // Partial remainder stays below the divisor, so the shifted value minus the
  // divisor always fits in WIDTH+1 bits and bit WIDTH is a true borrow.
  always_comb begin
    w_shrem = {acc[2*WIDTH-1:WIDTH], bit_in};
    w_trial = w_shrem - {1'b0, operand};
    if (is_div) begin
      if (w_trial[WIDTH]) acc_next = {w_shrem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                acc_next = {w_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0}
               + (bit_in ? {{WIDTH{1'b0}}, operand} : {(2*WIDTH){1'b0}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_sequencer : multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO
// Revision         : 1.0
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_bzero;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_neg_a = op[0] & a[WIDTH-1];
  assign w_neg_b = op[0] & b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -a : a;
  assign w_mag_b = w_neg_b ? -b : b;

  // Dividend / multiplier bits enter MSB first from r_sh.
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (r_acc),
    .operand  (r_opb),
    .bit_in   (r_sh[WIDTH-1]),
    .is_div   (r_is_div),
    .acc_next (w_acc_next)
  );

  // Divide by zero leaves quotient all ones and remainder = |A|; restoring the
  // dividend's sign on the remainder gives back A exactly.
  always_comb begin
    w_prod_neg = -r_acc;
    w_res_hi   = r_acc[2*WIDTH-1:WIDTH];
    w_res_lo   = r_acc[WIDTH-1:0];
    if (!r_is_div) begin
      if (r_neg_a ^ r_neg_b) {w_res_hi, w_res_lo} = w_prod_neg;
    end else begin
      if ((r_neg_a ^ r_neg_b) && !r_bzero) w_res_lo = -r_acc[WIDTH-1:0];
      if (r_neg_a)                         w_res_hi = -r_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wr_data;
          if (lo_we) r_lo <= wr_data;
          if (start && !flush) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_is_div <= op[1];
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_bzero  <= (b == '0);
            r_sh     <= w_mag_a;
            r_opb    <= w_mag_b;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            if (r_count == '0) r_state <= FIX;
            else               r_count <= r_count - CW'(1);
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is between edges. Pulses start, then counts edges to done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input bit noise);
    int lat;
    bit busy_ok;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (noise && lat == 3) begin
        start = 1'b1; op = 2'b00; a = '1; b = '1; hi_we = 1'b1; wr_data = 32'h1234;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
    end
    check({tag, " latency"}, lat, 33);
    check({tag, " busy_during"}, {31'd0, busy_ok}, 1);
    check({tag, " busy_at_done"}, {31'd0, busy}, 0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    // reset state
    #12;
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_neg",  2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu",      2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0);
    run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("divu_zero", 2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0);
    run_op("div_zero",  2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    // mid-run Start and HiWe must be ignored
    run_op("noise",     2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1);

    // MT writes in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("mthi", hi, 32'hA5A5A5A5);
    check("mtlo", lo, 32'hA5A5A5A5);
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);

    // Start together with Flush in IDLE is dropped
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    check("start_flush busy", {31'd0, busy}, 0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Flush at RUN cycle 10
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush busy", {31'd0, busy}, 0);
    flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("flush no_done", seen, 0);
    check("flush hi", hi, 32'hA5A5A5A5);
    check("flush lo", lo, 32'hA5A5A5A5);
    @(negedge clk);

    // asynchronous reset mid-run
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFF9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 0);
    check("arst hi", hi, 0);
    check("arst lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("arst no_done", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide controller for the MIPS150 execute stage. It sequences an iterative shift-add and shift-subtract datapath for MULT, MULTU, DIV and DIVU, and it owns the architectural HI/LO registers. It gives the pipeline a Busy/Done handshake so the hazard unit can stall MFHI/MFLO and any new mul/div while an operation runs. It sits beside the single-cycle ALU and takes the same rs/rt operands.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.

- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; accepted only in IDLE.
- Op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Sampled with Start.
- A  in  WIDTH  rs operand (multiplicand or dividend). Sampled with Start.
- B  in  WIDTH  rt operand (multiplier or divisor). Sampled with Start.
- Flush  in  1  abort on exception or branch squash.
- HiWe  in  1  MTHI write enable.
- LoWe  in  1  MTLO write enable.
- WrData  in  WIDTH  MTHI/MTLO data.
- Busy  out  1  high while state is not IDLE.
- Done  out  1  one-cycle registered pulse; HI/LO hold the new result while it is high.
- HI  out  WIDTH  HI register (remainder, or product upper half).
- LO  out  WIDTH  LO register (quotient, or product lower half).

## Operation
- States:
  - IDLE → RUN on Start & !Flush.
  - RUN → RUN while count ≠ 0; RUN → FIX when count = 0.
  - FIX → IDLE.
  - RUN or FIX → IDLE on Flush.
- Start accept:
  - Latch magnitudes |A| and |B| (signed ops only; unsigned ops take A/B as-is).
  - Latch the sign flags and the op.
  - Clear the 2·WIDTH accumulator; set count = WIDTH−1.
- RUN, one bit per cycle:
  - Multiply: shift-add on the accumulator.
  - Divide: restoring shift-subtract; the quotient bit shifts into the low half.
- FIX:
  - MULT: if the signs differ, negate the 2·WIDTH product.
  - DIV: if the signs differ, negate the quotient; the remainder takes the dividend's sign.
  - Write HI/LO; Done = 1 on the next cycle.
- Divide by zero (B = 0):
  - Full latency still applies.
  - LO = all ones, HI = A unmodified.
  - No sign fix-up.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of the magnitude path naturally.
- Start while Busy is ignored; there is no queue.
- HiWe/LoWe:
  - Honoured only in IDLE; ignored while Busy, because the pipeline guarantees a stall.
  - HiWe/LoWe in the same cycle as an accepted Start: the MT write lands, and the later result overwrites it.
- Flush:
  - State goes to IDLE on the next edge.
  - HI/LO keep their pre-operation values; no Done is issued.
  - Flush together with Start in IDLE: Start is dropped.

## Timing
- Edge 0 samples Start.
- Busy is high from edge 0 until edge WIDTH+1 (33).
- RUN occupies edges 1..WIDTH; FIX completes at edge WIDTH+1.
- Done is high from edge WIDTH+1 to WIDTH+2. Latency Start→Done is WIDTH+1 edges (33 for WIDTH = 32).
- Busy falls on the same edge that Done rises. A new Start is legal in the Done cycle.
- Reset values (asynchronous, immediate on Reset_n low): state IDLE, Busy 0, Done 0, HI 0, LO 0, count 0.
- Reset mid-operation: the operation is discarded and no Done is issued.
- HI/LO change only on FIX, MTHI/MTLO, or reset.

## Structure
- Package muldiv_pkg holds:
  - Op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - The state typedef: IDLE, RUN, FIX.
  - The WIDTH default.
- Sub-module muldiv_step is purely combinational, one iteration: accumulator, operand and op in; next accumulator out (add-shift or trial-subtract-shift).
- The FSM, counter, sign flags, HI/LO and handshake live in muldiv_sequencer.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Done exactly 33 edges after Start; Busy is high for every cycle in between.
- MULT 0xFFFFFFF9 (−7) × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- Divide signs:
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 2 → LO = 3, HI = 1.
- Divide corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- Flush and ignored inputs during an operation:
  - Flush at RUN cycle 10 → Busy low on the next edge, no Done, HI/LO unchanged.
  - Start pulsed mid-RUN → ignored.
  - HiWe with WrData = 0x1234 while Busy → HI unchanged.
- MT writes and reset:
  - IDLE HiWe/LoWe with 0xA5A5A5A5 → HI = LO = 0xA5A5A5A5 after one edge.
  - Reset_n low mid-RUN → HI = LO = 0 and Busy = 0 immediately, with no Done after release.
